// File: rtl/mem_stage_sram.sv
// MEM stage: passes EXE/MEM results through to MEM/WB and performs 32-bit
// loads/stores against a 16-bit asynchronous SRAM as two half-word accesses,
// holding the pipeline (ready low) while the access is in flight.
module mem_stage_sram #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_en,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_result,
  input  logic [31:0] ST_val,
  input  logic [3:0]  Dest,
  output logic        ready,
  output logic        WB_en_out,
  output logic        MEM_R_EN_out,
  output logic [31:0] ALU_result_out,
  output logic [3:0]  Dest_out,
  output logic [31:0] mem_read_value,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  input  logic [15:0] SRAM_DQ_in,
  output logic        SRAM_DQ_oe,
  output logic        SRAM_WE_N
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [31:0] BASE_W   = 32'(BASE_ADDR);
  localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES - 1);
  localparam logic        ONE_WAIT = (WAIT_CYCLES == 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rd_q, rd_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] dq_q, dq_d;

  logic        req;
  logic        rd_op;
  logic        wr_op;
  logic        last;
  logic        in_phase;
  logic [16:0] word;

  // A read takes priority when both enables are set.
  assign req      = MEM_R_EN | MEM_W_EN;
  assign rd_op    = MEM_R_EN;
  assign wr_op    = MEM_W_EN & ~MEM_R_EN;
  assign word     = 17'((ALU_result - BASE_W) >> 2);
  assign last     = (cnt_q == 4'd0);
  assign in_phase = (state_q == LO) || (state_q == HI);

  assign ready          = ~req | (state_q == DONE);
  assign WB_en_out      = WB_en & ready;
  assign MEM_R_EN_out   = MEM_R_EN & ready;
  assign ALU_result_out = ALU_result;
  assign Dest_out       = Dest;
  assign mem_read_value = rd_q;
  assign SRAM_ADDR      = addr_q;
  assign SRAM_DQ_out    = dq_q;

  // Write strobe rises on the last cycle of each phase so the SRAM latches on
  // WE_N rising while address/data are still held; one-cycle phases keep it low.
  assign SRAM_DQ_oe = wr_op & in_phase;
  assign SRAM_WE_N  = ~(SRAM_DQ_oe & (ONE_WAIT | ~last));

  // Next-state, wait counter, SRAM address/data and read-capture logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    dq_d    = dq_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = LO;
          cnt_d   = CNT_INIT;
          addr_d  = {word, 1'b0};
          dq_d    = ST_val[15:0];
        end
      end
      LO: begin
        if (last) begin
          if (rd_op) rd_d[15:0] = SRAM_DQ_in;
          state_d = HI;
          cnt_d   = CNT_INIT;
          addr_d  = {word, 1'b1};
          dq_d    = ST_val[31:16];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HI: begin
        if (last) begin
          if (rd_op) rd_d[31:16] = SRAM_DQ_in;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rd_q    <= 32'd0;
      addr_q  <= 18'd0;
      dq_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Bench for mem_stage_sram: two instances (WAIT_CYCLES = 1 and 3), each with
// its own SRAM model, a cycle-level reference model, and directed vectors.
module tb_mem_stage_sram;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        wb_en [2];
  logic        r_en  [2];
  logic        w_en  [2];
  logic [31:0] alu   [2];
  logic [31:0] st    [2];
  logic [3:0]  dest  [2];
  logic        ready [2];
  logic        wbo   [2];
  logic        ro    [2];
  logic [31:0] alu_o [2];
  logic [3:0]  dest_o[2];
  logic [31:0] rdv   [2];
  logic [17:0] saddr [2];
  logic [15:0] sdq_o [2];
  logic [15:0] sdq_i [2];
  logic        soe   [2];
  logic        swen  [2];
  logic [15:0] sram  [2][64];

  int checks = 0;
  int errs   = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_stage_sram #(.BASE_ADDR(1024), .WAIT_CYCLES((g == 0) ? 1 : 3)) u_dut (
      .clk(clk), .rst(rst), .WB_en(wb_en[g]), .MEM_R_EN(r_en[g]), .MEM_W_EN(w_en[g]),
      .ALU_result(alu[g]), .ST_val(st[g]), .Dest(dest[g]), .ready(ready[g]),
      .WB_en_out(wbo[g]), .MEM_R_EN_out(ro[g]), .ALU_result_out(alu_o[g]),
      .Dest_out(dest_o[g]), .mem_read_value(rdv[g]), .SRAM_ADDR(saddr[g]),
      .SRAM_DQ_out(sdq_o[g]), .SRAM_DQ_in(sdq_i[g]), .SRAM_DQ_oe(soe[g]),
      .SRAM_WE_N(swen[g]));
    assign sdq_i[g] = sram[g][saddr[g][5:0]];
  end

  function automatic int wc(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [16:0] word_of(input logic [31:0] a);
    logic [31:0] d;
    d = (a - 32'd1024) >> 2;
    return d[16:0];
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s inst%0d: got %h, expected %h", nm, i, act, exp);
    end
  endtask

  // SRAM environment: latches data on any clock edge where the strobe is low.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int a = 0; a < 64; a++) sram[i][a] <= 16'h0;
      end else if (!swen[i]) begin
        sram[i][saddr[i][5:0]] <= sdq_o[i];
      end
    end
  end

  // Reference model: k counts cycles a request has been held (0 = request
  // cycle, 1..W low half, W+1..2W high half, 2W+1 = release cycle).
  int          k  [2] = '{0, 0};
  logic [17:0] ea [2] = '{18'd0, 18'd0};
  logic [31:0] erd[2] = '{32'd0, 32'd0};

  always @(posedge clk or posedge rst) begin
    int w;
    logic [17:0] lo_a, hi_a;
    for (int i = 0; i < 2; i++) begin
      w    = wc(i);
      lo_a = {word_of(alu[i]), 1'b0};
      hi_a = {word_of(alu[i]), 1'b1};
      if (rst) begin
        k[i] <= 0; ea[i] <= 18'd0; erd[i] <= 32'd0;
      end else if (r_en[i] | w_en[i]) begin
        if (k[i] == 0) ea[i] <= lo_a;
        if (k[i] == w) begin
          ea[i] <= hi_a;
          if (r_en[i]) erd[i][15:0] <= sram[i][lo_a[5:0]];
        end
        if (k[i] == 2 * w && r_en[i]) erd[i][31:16] <= sram[i][hi_a[5:0]];
        k[i] <= (k[i] == 2 * w + 1) ? 0 : k[i] + 1;
      end else begin
        k[i] <= 0;
      end
    end
  end

  // Compare every output of both instances against the model each cycle.
  always @(negedge clk) begin
    int w, pos;
    logic req, e_ready, in_lo, in_hi, e_oe, e_wen;
    for (int i = 0; i < 2; i++) begin
      w       = wc(i);
      req     = r_en[i] | w_en[i];
      e_ready = !req || (k[i] == 2 * w + 1);
      in_lo   = req && (k[i] >= 1) && (k[i] <= w);
      in_hi   = req && (k[i] > w) && (k[i] <= 2 * w);
      pos     = in_lo ? k[i] - 1 : k[i] - w - 1;
      e_oe    = w_en[i] && !r_en[i] && (in_lo || in_hi);
      e_wen   = !(e_oe && ((w == 1) || (pos != w - 1)));
      chk("m_ready", i, 32'(ready[i]), 32'(e_ready));
      chk("m_wb_en_out", i, 32'(wbo[i]), 32'(wb_en[i] & e_ready));
      chk("m_mem_r_en_out", i, 32'(ro[i]), 32'(r_en[i] & e_ready));
      chk("m_alu_out", i, alu_o[i], alu[i]);
      chk("m_dest_out", i, 32'(dest_o[i]), 32'(dest[i]));
      chk("m_read_value", i, rdv[i], erd[i]);
      chk("m_sram_addr", i, 32'(saddr[i]), 32'(ea[i]));
      chk("m_sram_oe", i, 32'(soe[i]), 32'(e_oe));
      chk("m_sram_we_n", i, 32'(swen[i]), 32'(e_wen));
      if (e_oe) chk("m_sram_dq", i, 32'(sdq_o[i]), in_lo ? 32'(st[i][15:0]) : 32'(st[i][31:16]));
    end
  end

  logic        lg_ready[64];
  logic        lg_wen  [64];
  logic        lg_wbo  [64];
  logic [17:0] lg_addr [64];
  logic [15:0] lg_dq   [64];
  logic [31:0] lg_rd   [64];

  task automatic drive(input int i, input logic wb, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] s, input logic [3:0] d);
    wb_en[i] = wb; r_en[i] = r; w_en[i] = w; alu[i] = a; st[i] = s; dest[i] = d;
  endtask

  // Apply one instruction at posedge+1, log each cycle until ready, then step
  // one edge; leaves the inputs applied unless idle_after is set.
  task automatic run_op(input int i, input logic wb, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] s, input logic [3:0] d,
                        input bit idle_after, output int stall);
    drive(i, wb, r, w, a, s, d);
    stall = -1;
    for (int j = 0; j < 64; j++) begin
      @(negedge clk);
      lg_ready[j] = ready[i]; lg_wen[j] = swen[i]; lg_wbo[j] = wbo[i];
      lg_addr[j] = saddr[i]; lg_dq[j] = sdq_o[i]; lg_rd[j] = rdv[i];
      if (ready[i]) begin
        stall = j;
        break;
      end
    end
    if (stall < 0) begin
      checks++; errs++;
      $display("FAIL ready_timeout inst%0d: ready never rose within 64 cycles", i);
      stall = 0;
    end
    @(posedge clk); #1;
    if (idle_after) drive(i, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  initial begin
    int s;
    logic any_low;
    for (int i = 0; i < 2; i++) drive(i, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", i, 32'(ready[i]), 32'd1);
      chk("rst_we_n", i, 32'(swen[i]), 32'd1);
      chk("rst_oe", i, 32'(soe[i]), 32'd0);
      chk("rst_addr", i, 32'(saddr[i]), 32'd0);
      chk("rst_dq", i, 32'(sdq_o[i]), 32'd0);
      chk("rst_read_value", i, rdv[i], 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Pass-through ALU op
    drive(0, 1'b1, 1'b0, 1'b0, 32'h55, 32'd0, 4'd3);
    #1;
    chk("pt_ready", 0, 32'(ready[0]), 32'd1);
    chk("pt_wb_en_out", 0, 32'(wbo[0]), 32'd1);
    chk("pt_alu_out", 0, alu_o[0], 32'h55);
    chk("pt_dest_out", 0, 32'(dest_o[0]), 32'd3);
    chk("pt_we_n", 0, 32'(swen[0]), 32'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

    // Store 0xDEADBEEF at 1032, WAIT_CYCLES = 1
    run_op(0, 1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 4'd0, 1'b1, s);
    chk("st1_stall", 0, 32'(s), 32'd3);
    chk("st1_lo_addr", 0, 32'(lg_addr[1]), 32'd4);
    chk("st1_lo_dq", 0, 32'(lg_dq[1]), 32'hBEEF);
    chk("st1_lo_we_n", 0, 32'(lg_wen[1]), 32'd0);
    chk("st1_hi_addr", 0, 32'(lg_addr[2]), 32'd5);
    chk("st1_hi_dq", 0, 32'(lg_dq[2]), 32'hDEAD);
    chk("st1_hi_we_n", 0, 32'(lg_wen[2]), 32'd0);
    chk("st1_done_we_n", 0, 32'(lg_wen[3]), 32'd1);

    // Load it back
    run_op(0, 1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 4'd5, 1'b1, s);
    chk("ld1_stall", 0, 32'(s), 32'd3);
    chk("ld1_value", 0, lg_rd[3], 32'hDEADBEEF);
    chk("ld1_wb_stall", 0, 32'({lg_wbo[0], lg_wbo[1], lg_wbo[2]}), 32'd0);
    chk("ld1_wb_done", 0, 32'(lg_wbo[3]), 32'd1);

    // WAIT_CYCLES = 3 store then load
    run_op(1, 1'b0, 1'b0, 1'b1, 32'd1032, 32'hABCD1234, 4'd0, 1'b1, s);
    chk("st3_stall", 1, 32'(s), 32'd7);
    chk("st3_we_n_pattern", 1, 32'({lg_wen[1], lg_wen[2], lg_wen[3], lg_wen[4], lg_wen[5], lg_wen[6]}), 32'b001001);
    run_op(1, 1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 4'd7, 1'b1, s);
    chk("ld3_stall", 1, 32'(s), 32'd7);
    for (int j = 1; j <= 3; j++) chk("ld3_lo_addr", 1, 32'(lg_addr[j]), 32'd4);
    for (int j = 4; j <= 6; j++) chk("ld3_hi_addr", 1, 32'(lg_addr[j]), 32'd5);
    chk("ld3_value", 1, lg_rd[7], 32'hABCD1234);

    // Back-to-back loads
    run_op(0, 1'b0, 1'b0, 1'b1, 32'd1036, 32'h0BADF00D, 4'd0, 1'b1, s);
    run_op(0, 1'b1, 1'b1, 1'b0, 32'd1036, 32'd0, 4'd1, 1'b0, s);
    chk("b2b_first_stall", 0, 32'(s), 32'd3);
    chk("b2b_first_value", 0, lg_rd[3], 32'h0BADF00D);
    run_op(0, 1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 4'd2, 1'b1, s);
    chk("b2b_second_stall", 0, 32'(s), 32'd3);
    chk("b2b_second_value", 0, lg_rd[3], 32'hDEADBEEF);

    // Both enables set: acts as a read
    run_op(0, 1'b1, 1'b1, 1'b1, 32'd1032, 32'h11112222, 4'd4, 1'b1, s);
    any_low = 1'b0;
    for (int j = 0; j <= 3; j++) if (!lg_wen[j]) any_low = 1'b1;
    chk("both_stall", 0, 32'(s), 32'd3);
    chk("both_we_n_low_seen", 0, 32'(any_low), 32'd0);
    chk("both_value", 0, lg_rd[3], 32'hDEADBEEF);

    // Address below the base wraps
    run_op(0, 1'b0, 1'b0, 1'b1, 32'd1020, 32'h55AA0FF0, 4'd0, 1'b1, s);
    chk("wrap_lo_addr", 0, 32'(lg_addr[1]), 32'h3FFFE);
    chk("wrap_hi_addr", 0, 32'(lg_addr[2]), 32'h3FFFF);

    // Reset in the middle of the low half of a WAIT_CYCLES = 3 write
    drive(1, 1'b0, 1'b0, 1'b1, 32'd1032, 32'h77778888, 4'd0);
    @(posedge clk); #2;
    chk("mid_lo_we_n", 1, 32'(swen[1]), 32'd0);
    rst = 1'b1;
    #1;
    chk("arst_we_n", 1, 32'(swen[1]), 32'd1);
    chk("arst_oe", 1, 32'(soe[1]), 32'd0);
    chk("arst_read_value", 1, rdv[1], 32'd0);
    chk("arst_addr", 1, 32'(saddr[1]), 32'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_ready", 1, 32'(ready[1]), 32'd1);
    chk("post_rst_we_n", 1, 32'(swen[1]), 32'd1);
    @(posedge clk); #1;
    run_op(1, 1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 4'd6, 1'b1, s);
    chk("post_rst_ld_stall", 1, 32'(s), 32'd7);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule
